// File: rtl/instr_fetch_if.sv
// instr_fetch_if: sram read port, decoder handshake and redirect
// signals shared by the fetch stage and its neighbours.
interface instr_fetch_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned WIDTH  = 8
);
   logic              en;
   logic              mem_cs;
   logic [ADDR_W-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_data;
   logic [WIDTH-1:0]  instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              jump_en;
   logic [ADDR_W-1:0] jump_addr;
   logic              halted;

   modport master (
      input  en,
      input  mem_data,
      input  instr_ready,
      input  jump_en,
      input  jump_addr,
      output mem_cs,
      output mem_addr,
      output instr,
      output instr_pc,
      output instr_valid,
      output halted
   );

   modport slave (
      output en,
      output mem_data,
      output instr_ready,
      output jump_en,
      output jump_addr,
      input  mem_cs,
      input  mem_addr,
      input  instr,
      input  instr_pc,
      input  instr_valid,
      input  halted
   );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven fetch stage in front of a 1-cycle sram.
// Define FETCH_HALT_EN to stop fetching after a HALT_OP word.
module instr_fetch #(
   parameter int unsigned       ADDR_W   = 4,
   parameter int unsigned       WIDTH    = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [WIDTH-1:0]  HALT_OP  = 8'hFF
) (
   input logic           clk,
   input logic           rst_n,
   instr_fetch_if.master bus
);

`ifdef FETCH_HALT_EN
   typedef enum logic [2:0] {
      IDLE, REQ, CAPT, HOLD, HALTED
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE, REQ, CAPT, HOLD
   } state_t;
`endif

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [WIDTH-1:0]  instr_q;
   logic [ADDR_W-1:0] instr_pc_q;
   logic              valid_q;

`ifdef FETCH_HALT_EN
   logic              halt_hit_q;
`else
   logic              halt_op_unused;
   assign halt_op_unused = ^HALT_OP;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // A redirect overrides whatever the FSM was doing.
   always_comb begin
      state_d = state_q;
      if (bus.jump_en) begin
         state_d = bus.en ? REQ : IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (bus.en) state_d = REQ;
            REQ:  state_d = CAPT;
            CAPT: state_d = HOLD;
            HOLD: begin
               if (bus.instr_ready) begin
`ifdef FETCH_HALT_EN
                  if (halt_hit_q)
                     state_d = HALTED;
                  else
                     state_d = bus.en ? REQ : IDLE;
`else
                  state_d = bus.en ? REQ : IDLE;
`endif
               end
            end
`ifdef FETCH_HALT_EN
            HALTED: state_d = HALTED;
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
`ifdef FETCH_HALT_EN
         halt_hit_q <= 1'b0;
`endif
      end else if (bus.jump_en) begin
         pc_q    <= bus.jump_addr;
         valid_q <= 1'b0;
      end else if (state_q == CAPT) begin
         instr_q    <= bus.mem_data;
         instr_pc_q <= pc_q;
         valid_q    <= 1'b1;
         pc_q       <= pc_q + 1'b1;
`ifdef FETCH_HALT_EN
         halt_hit_q <= (bus.mem_data == HALT_OP);
`endif
      end else if (state_q == HOLD && bus.instr_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.mem_cs      = (state_q == REQ);
   assign bus.mem_addr    = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = valid_q;

`ifdef FETCH_HALT_EN
   assign bus.halted = (state_q == HALTED);
`else
   assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus a randomized run
// scored against a next-word model of the fetch stream.
module tb_instr_fetch;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [7:0] mem [16];

   instr_fetch_if #(.ADDR_W(4), .WIDTH(8)) fif ();

   instr_fetch #(
      .ADDR_W(4), .WIDTH(8),
      .RESET_PC(4'd0), .HALT_OP(8'hFF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(fif)
   );

   always #5 clk = ~clk;

   // sram: 1-cycle read latency
   always @(posedge clk)
      if (fif.mem_cs) fif.mem_data <= mem[fif.mem_addr];

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      fif.en = 1'b0;
      fif.instr_ready = 1'b0;
      fif.jump_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (fif.instr_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      fif.en = 1'b0;
      fif.instr_ready = 1'b0;
      fif.jump_en = 1'b0;
      fif.jump_addr = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (fif.instr_valid !== 1'b0 || fif.mem_cs !== 1'b0 ||
          fif.instr !== 8'h00 || fif.instr_pc !== 4'd0 ||
          fif.halted !== 1'b0 || fif.mem_addr !== 4'd0) begin
         failures++;
         $display("FAIL reset_values: v=%b cs=%b i=%h pc=%h h=%b a=%h want 0s",
                  fif.instr_valid, fif.mem_cs, fif.instr,
                  fif.instr_pc, fif.halted, fif.mem_addr);
      end
      rst_n = 1'b1;
      fif.en = 1'b1;
      fif.instr_ready = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (fif.mem_addr !== 4'd1) begin
         failures++;
         $display("FAIL prereset_addr: got %h want 1", fif.mem_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (fif.instr_valid !== 1'b0 || fif.mem_cs !== 1'b0 ||
          fif.mem_addr !== 4'd0) begin
         failures++;
         $display("FAIL async_reset: v=%b cs=%b a=%h want 0 0 0",
                  fif.instr_valid, fif.mem_cs, fif.mem_addr);
      end
   endtask

   task automatic test_stream();
      @(negedge clk);
      fif.en = 1'b1;
      fif.instr_ready = 1'b1;
      rst_n = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         checks++;
         if (fif.mem_cs !== (k % 3 == 1) ||
             fif.instr_valid !== (k % 3 == 0)) begin
            failures++;
            $display("FAIL stream_timing k=%0d: cs=%b v=%b want %b %b",
                     k, fif.mem_cs, fif.instr_valid,
                     k % 3 == 1, k % 3 == 0);
         end
         if (k % 3 == 0) begin
            checks++;
            if (fif.instr !== mem[k/3-1] || fif.instr_pc !== 4'(k/3-1)) begin
               failures++;
               $display("FAIL stream_word k=%0d: got %h@%0d want %h@%0d",
                        k, fif.instr, fif.instr_pc, mem[k/3-1], k/3-1);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      do_reset();
      fif.en = 1'b1;
      fif.instr_ready = 1'b1;
      wait_valid(6, ok);
      wait_valid(6, ok);
      checks++;
      if (!ok || fif.instr_pc !== 4'd1) begin
         failures++;
         $display("FAIL bp_first: ok=%b pc=%h want pc 1", ok, fif.instr_pc);
      end
      fif.instr_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (fif.instr_valid !== 1'b1 || fif.instr !== 8'h11 ||
             fif.instr_pc !== 4'd1 || fif.mem_cs !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold c=%0d: v=%b i=%h pc=%h cs=%b",
                     c, fif.instr_valid, fif.instr, fif.instr_pc, fif.mem_cs);
         end
      end
      fif.instr_ready = 1'b1;
      @(negedge clk);
      wait_valid(6, ok);
      checks++;
      if (!ok || fif.instr !== 8'h12 || fif.instr_pc !== 4'd2) begin
         failures++;
         $display("FAIL bp_next: ok=%b got %h@%h want 12@2",
                  ok, fif.instr, fif.instr_pc);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      fif.jump_en = 1'b1;
      fif.jump_addr = 4'd15;
      @(negedge clk);
      fif.jump_en = 1'b0;
      wait_valid(8, ok);
      checks++;
      if (!ok || fif.instr !== 8'h1F || fif.instr_pc !== 4'd15) begin
         failures++;
         $display("FAIL wrap_15: ok=%b got %h@%h want 1f@f",
                  ok, fif.instr, fif.instr_pc);
      end
      wait_valid(8, ok);
      checks++;
      if (!ok || fif.instr !== 8'h10 || fif.instr_pc !== 4'd0) begin
         failures++;
         $display("FAIL wrap_0: ok=%b got %h@%h want 10@0",
                  ok, fif.instr, fif.instr_pc);
      end
   endtask

   task automatic test_jump_capt();
      bit ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         ok = fif.mem_cs;
      end
      @(negedge clk);
      fif.jump_en = 1'b1;
      fif.jump_addr = 4'd9;
      @(negedge clk);
      fif.jump_en = 1'b0;
      checks++;
      if (!ok || fif.instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL jcapt_drop: req=%b v=%b want 1 0",
                  ok, fif.instr_valid);
      end
      wait_valid(8, ok);
      checks++;
      if (!ok || fif.instr !== 8'h19 || fif.instr_pc !== 4'd9) begin
         failures++;
         $display("FAIL jcapt_next: ok=%b got %h@%h want 19@9",
                  ok, fif.instr, fif.instr_pc);
      end
   endtask

   task automatic test_en_drop();
      bit ok;
      @(negedge clk);
      checks++;
      if (fif.mem_cs !== 1'b1 || fif.mem_addr !== 4'd10) begin
         failures++;
         $display("FAIL endrop_req: cs=%b a=%h want 1 a",
                  fif.mem_cs, fif.mem_addr);
      end
      fif.en = 1'b0;
      wait_valid(4, ok);
      checks++;
      if (!ok || fif.instr !== 8'h1A || fif.instr_pc !== 4'd10) begin
         failures++;
         $display("FAIL endrop_word: ok=%b got %h@%h want 1a@a",
                  ok, fif.instr, fif.instr_pc);
      end
      ok = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (fif.mem_cs || fif.instr_valid) ok = 1'b1;
      end
      checks++;
      if (ok) begin
         failures++;
         $display("FAIL endrop_idle: activity=1 want 0");
      end
   endtask

   task automatic test_halt();
      bit ok;
      do_reset();
      fif.en = 1'b1;
      fif.instr_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_valid(8, ok);
         checks++;
         if (!ok || fif.instr !== mem[i] || fif.instr_pc !== 4'(i)) begin
            failures++;
            $display("FAIL halt_run i=%0d: ok=%b got %h@%h want %h",
                     i, ok, fif.instr, fif.instr_pc, mem[i]);
         end
      end
`ifdef FETCH_HALT_EN
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (fif.halted !== 1'b1 || fif.mem_cs !== 1'b0 ||
             fif.instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_stop c=%0d: h=%b cs=%b v=%b want 1 0 0",
                     c, fif.halted, fif.mem_cs, fif.instr_valid);
         end
      end
      fif.jump_en = 1'b1;
      fif.jump_addr = 4'd2;
      @(negedge clk);
      fif.jump_en = 1'b0;
      checks++;
      if (fif.halted !== 1'b0) begin
         failures++;
         $display("FAIL halt_clear: got %b want 0", fif.halted);
      end
      wait_valid(8, ok);
      checks++;
      if (!ok || fif.instr !== 8'h12 || fif.instr_pc !== 4'd2) begin
         failures++;
         $display("FAIL halt_resume: ok=%b got %h@%h want 12@2",
                  ok, fif.instr, fif.instr_pc);
      end
`else
      wait_valid(8, ok);
      checks++;
      if (!ok || fif.instr !== 8'h16 || fif.instr_pc !== 4'd6 ||
          fif.halted !== 1'b0) begin
         failures++;
         $display("FAIL nohalt_next: ok=%b got %h@%h h=%b want 16@6 0",
                  ok, fif.instr, fif.instr_pc, fif.halted);
      end
`endif
   endtask

   task automatic test_random();
      logic [3:0] exp_pc = 4'd0;
      bit         mhalt = 1'b0;
      bit         jmp, acc;
      logic [3:0] ja;
      int         n_acc = 0;
      do_reset();
      fif.en = 1'b1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (fif.instr_valid) begin
            checks++;
            if (fif.instr !== mem[exp_pc] || fif.instr_pc !== exp_pc) begin
               failures++;
               $display("FAIL rand_word c=%0d: got %h@%h want %h@%h",
                        c, fif.instr, fif.instr_pc, mem[exp_pc], exp_pc);
            end
         end
         if (fif.mem_cs) begin
            checks++;
            if (fif.mem_addr !== exp_pc || fif.instr_valid) begin
               failures++;
               $display("FAIL rand_req c=%0d: a=%h v=%b want %h 0",
                        c, fif.mem_addr, fif.instr_valid, exp_pc);
            end
         end
`ifdef FETCH_HALT_EN
         checks++;
         if (fif.halted !== mhalt ||
             (mhalt && (fif.mem_cs || fif.instr_valid))) begin
            failures++;
            $display("FAIL rand_halt c=%0d: h=%b cs=%b v=%b want h=%b",
                     c, fif.halted, fif.mem_cs, fif.instr_valid, mhalt);
         end
`endif
         fif.instr_ready = ($urandom_range(0, 99) < 60);
         jmp = ($urandom_range(0, 19) == 0);
         ja = 4'($urandom_range(0, 15));
         fif.jump_en = jmp;
         fif.jump_addr = ja;
         acc = fif.instr_valid && fif.instr_ready;
         if (jmp) begin
            exp_pc = ja;
            mhalt = 1'b0;
         end else if (acc) begin
`ifdef FETCH_HALT_EN
            if (mem[exp_pc] == 8'hFF) mhalt = 1'b1;
`endif
            exp_pc = exp_pc + 4'd1;
         end
         if (acc) n_acc++;
      end
      fif.jump_en = 1'b0;
      checks++;
      if (n_acc < 20) begin
         failures++;
         $display("FAIL rand_progress: accepts=%0d want >=20", n_acc);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
      mem[5] = 8'hFF;
      fif.mem_data = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_wrap();
      test_jump_capt();
      test_en_drop();
      test_halt();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
